// File: rtl/phy_lane_sched.sv
// Four-lane round-robin byte scheduler feeding a serializer, with a training preamble after reset/retrain.
// Optional per-lane transfer counters (cnt_0..cnt_3) when PHY_SCHED_STATS_EN is defined.
module phy_lane_sched #(
   parameter int unsigned TRAIN_CYCLES = 4,
   parameter logic [7:0]  BC_SYM       = 8'hBC,
   parameter logic [7:0]  IDLE_SYM     = 8'h7C
) (
   input  logic        clk_4f,
   input  logic        rst,
   input  logic        retrain,
   input  logic        valid_in_0,
   input  logic        valid_in_1,
   input  logic        valid_in_2,
   input  logic        valid_in_3,
   input  logic [7:0]  data_in_0,
   input  logic [7:0]  data_in_1,
   input  logic [7:0]  data_in_2,
   input  logic [7:0]  data_in_3,
   output logic        ready_0,
   output logic        ready_1,
   output logic        ready_2,
   output logic        ready_3,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic [1:0]  lane_id,
   output logic        link_up
`ifdef PHY_SCHED_STATS_EN
   ,
   output logic [7:0]  cnt_0,
   output logic [7:0]  cnt_1,
   output logic [7:0]  cnt_2,
   output logic [7:0]  cnt_3
`endif
);

   typedef enum logic {TRAIN, ACTIVE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  train_cnt, train_cnt_nxt;
   logic [1:0]  ptr, ptr_nxt;
   logic [7:0]  data_nxt;
   logic        valid_nxt;
   logic [1:0]  lane_nxt;

   logic [3:0]  vin;
   logic [7:0]  din [4];
   logic [1:0]  gnt_idx;
   logic [1:0]  cand;
   logic        gnt_any;
   logic        sched_en;
   logic        xfer;
   logic [3:0]  rdy;

   always_comb begin
      vin    = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
      din[0] = data_in_0;
      din[1] = data_in_1;
      din[2] = data_in_2;
      din[3] = data_in_3;
   end

   // First pending lane at or after ptr, wrapping modulo 4.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = ptr;
      cand    = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         cand = ptr + 2'(k);
         if (!gnt_any && vin[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      sched_en = (state == ACTIVE) && !retrain && !rst;
      xfer     = sched_en && gnt_any;
      rdy      = xfer ? (4'b0001 << gnt_idx) : '0;
   end

   assign ready_0 = rdy[0];
   assign ready_1 = rdy[1];
   assign ready_2 = rdy[2];
   assign ready_3 = rdy[3];

   always_comb begin
      state_nxt     = state;
      train_cnt_nxt = train_cnt;
      ptr_nxt       = ptr;
      data_nxt      = BC_SYM;
      valid_nxt     = 1'b0;
      lane_nxt      = lane_id;
      case (state)
         TRAIN: begin
            train_cnt_nxt = train_cnt + 8'd1;
            if (train_cnt == 8'(TRAIN_CYCLES - 1)) begin
               state_nxt     = ACTIVE;
               train_cnt_nxt = '0;
            end
         end
         ACTIVE: begin
            if (retrain) begin
               state_nxt     = TRAIN;
               train_cnt_nxt = '0;
            end else if (xfer) begin
               data_nxt  = din[gnt_idx];
               valid_nxt = 1'b1;
               lane_nxt  = gnt_idx;
               ptr_nxt   = gnt_idx + 2'd1;
            end else begin
               data_nxt = IDLE_SYM;
            end
         end
         default: state_nxt = TRAIN;
      endcase
   end

   always_ff @(posedge clk_4f) begin
      if (rst) begin
         state     <= TRAIN;
         train_cnt <= '0;
         ptr       <= '0;
         data_out  <= BC_SYM;
         valid_out <= 1'b0;
         lane_id   <= '0;
         link_up   <= 1'b0;
      end else begin
         state     <= state_nxt;
         train_cnt <= train_cnt_nxt;
         ptr       <= ptr_nxt;
         data_out  <= data_nxt;
         valid_out <= valid_nxt;
         lane_id   <= lane_nxt;
         link_up   <= (state_nxt == ACTIVE);
      end
   end

`ifdef PHY_SCHED_STATS_EN
   logic [7:0] stat [4];

   always_ff @(posedge clk_4f) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) stat[i] <= '0;
      end else if (xfer && (stat[gnt_idx] != 8'hFF)) begin
         stat[gnt_idx] <= stat[gnt_idx] + 8'd1;
      end
   end

   assign cnt_0 = stat[0];
   assign cnt_1 = stat[1];
   assign cnt_2 = stat[2];
   assign cnt_3 = stat[3];
`endif

endmodule

// File: tb/tb_phy_lane_sched.sv
// Directed bench for phy_lane_sched: a per-cycle behavioural model plus literal checkpoints.
// Define PHY_SCHED_STATS_EN to also exercise the per-lane transfer counters.
module tb_phy_lane_sched;

   localparam int TC = 4;

   logic       clk;
   logic       rst;
   logic       retrain;
   logic [3:0] vin;
   logic [7:0] din [4];
   logic       ready_0, ready_1, ready_2, ready_3;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_id;
   logic       link_up;
`ifdef PHY_SCHED_STATS_EN
   logic [7:0] cnt [4];
`endif

   int n_vec = 0;
   int n_err = 0;

   phy_lane_sched #(.TRAIN_CYCLES(TC), .BC_SYM(8'hBC), .IDLE_SYM(8'h7C)) dut (
      .clk_4f     (clk),
      .rst        (rst),
      .retrain    (retrain),
      .valid_in_0 (vin[0]),
      .valid_in_1 (vin[1]),
      .valid_in_2 (vin[2]),
      .valid_in_3 (vin[3]),
      .data_in_0  (din[0]),
      .data_in_1  (din[1]),
      .data_in_2  (din[2]),
      .data_in_3  (din[3]),
      .ready_0    (ready_0),
      .ready_1    (ready_1),
      .ready_2    (ready_2),
      .ready_3    (ready_3),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .lane_id    (lane_id),
      .link_up    (link_up)
`ifdef PHY_SCHED_STATS_EN
      ,
      .cnt_0      (cnt[0]),
      .cnt_1      (cnt[1]),
      .cnt_2      (cnt[2]),
      .cnt_3      (cnt[3])
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: link mode, training cycles left, rotation start lane, last emitted symbol.
   bit m_init = 0;
   bit m_active;
   int m_left;
   int m_ptr;
   int m_data;
   int m_valid;
   int m_lane;
   int m_cnt [4];

   function automatic int pick(input int p, input logic [3:0] v);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   initial begin
      int g;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_init = 1; m_active = 0; m_left = TC; m_ptr = 0;
            m_data = 8'hBC; m_valid = 0; m_lane = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         end else if (m_init) begin
            if (!m_active) begin
               m_data = 8'hBC; m_valid = 0;
               m_left = m_left - 1;
               if (m_left == 0) m_active = 1;
            end else if (retrain) begin
               m_active = 0; m_left = TC; m_data = 8'hBC; m_valid = 0;
            end else begin
               g = pick(m_ptr, vin);
               if (g >= 0) begin
                  m_data = din[g]; m_valid = 1; m_lane = g; m_ptr = (g + 1) % 4;
                  if (m_cnt[g] < 255) m_cnt[g] = m_cnt[g] + 1;
               end else begin
                  m_data = 8'h7C; m_valid = 0;
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] rdy;
      int g;
      forever begin
         @(negedge clk);
         if (m_init) begin
            rdy = {ready_3, ready_2, ready_1, ready_0};
            g = (!rst && m_active && !retrain) ? pick(m_ptr, vin) : -1;
            for (int i = 0; i < 4; i++)
               check($sformatf("ready_%0d", i), int'(rdy[i]), int'(g == i));
            check("data_out", int'(data_out), m_data);
            check("valid_out", int'(valid_out), m_valid);
            check("lane_id", int'(lane_id), m_lane);
            check("link_up", int'(link_up), int'(m_active));
`ifdef PHY_SCHED_STATS_EN
            for (int i = 0; i < 4; i++)
               check($sformatf("cnt_%0d", i), int'(cnt[i]), m_cnt[i]);
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_data"}, int'(data_out), 8'hBC);
      check({tag, "_valid"}, int'(valid_out), 0);
      check({tag, "_lane"}, int'(lane_id), 0);
      check({tag, "_link"}, int'(link_up), 0);
   endtask

   initial begin
      rst = 1'b1; retrain = 1'b0; vin = '0;
      for (int i = 0; i < 4; i++) din[i] = '0;
      tick(); tick();
      rst = 1'b0;
      check_reset_vals("rst0");

      // Training preamble then idle fill.
      for (int t = 1; t <= 5; t++) begin
         tick();
         if (t <= 4) check("train_bc", int'(data_out), 8'hBC);
         if (t == 3) check("train_link", int'(link_up), 0);
         if (t == 4) check("up_link", int'(link_up), 1);
         if (t == 5) begin
            check("idle_data", int'(data_out), 8'h7C);
            check("idle_link", int'(link_up), 1);
            check("idle_valid", int'(valid_out), 0);
         end
      end

      // All lanes pending: strict rotation 0,1,2,3,0.
      din[0] = 8'h10; din[1] = 8'h20; din[2] = 8'h30; din[3] = 8'h40;
      vin = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rr_lane", int'(lane_id), i % 4);
         check("rr_data", int'(data_out), ((i % 4) + 1) * 16);
         check("rr_valid", int'(valid_out), 1);
      end
      vin = '0;

      // Move ptr to 2 via a lane-1 transfer, then lanes 1 and 3 compete.
      vin[1] = 1'b1; din[1] = 8'h51;
      tick();
      check("p2_lane", int'(lane_id), 1);
      check("p2_data", int'(data_out), 8'h51);
      din[1] = 8'h61; vin[3] = 1'b1; din[3] = 8'h63;
      #1;
      check("p2_rdy3", int'(ready_3), 1);
      check("p2_rdy1", int'(ready_1), 0);
      tick();
      check("s3a_lane", int'(lane_id), 3);
      check("s3a_data", int'(data_out), 8'h63);
      din[3] = 8'h73;
      tick();
      check("s1_lane", int'(lane_id), 1);
      check("s1_data", int'(data_out), 8'h61);
      tick();
      check("s3b_lane", int'(lane_id), 3);
      check("s3b_data", int'(data_out), 8'h73);
      vin = '0;

      // Retrain wins over a pending lane; a second retrain during training is ignored.
      vin[2] = 1'b1; din[2] = 8'h22; retrain = 1'b1;
      #1;
      check("rt_rdy2", int'(ready_2), 0);
      tick();
      retrain = 1'b0;
      check("rt_data", int'(data_out), 8'hBC);
      check("rt_link", int'(link_up), 0);
      for (int t = 1; t <= 4; t++) begin
         tick();
         retrain = (t == 1);
         check("rt_bc", int'(data_out), 8'hBC);
         check("rt_link_t", int'(link_up), int'(t == 4));
      end
      tick();
      check("rt_lane", int'(lane_id), 2);
      check("rt_data2", int'(data_out), 8'h22);
      check("rt_up", int'(link_up), 1);
      vin = '0;

      // Reset mid-transfer and mid-training; rotation restarts at lane 0.
      vin[0] = 1'b1; din[0] = 8'h0A; vin[1] = 1'b1; din[1] = 8'h1B; rst = 1'b1;
      #1;
      check("rs_rdy0", int'(ready_0), 0);
      check("rs_rdy1", int'(ready_1), 0);
      tick();
      rst = 1'b0;
      check_reset_vals("rst1");
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("rst2");
      repeat (4) tick();
      check("rs_up", int'(link_up), 1);
      tick();
      check("rs_lane0", int'(lane_id), 0);
      check("rs_data0", int'(data_out), 8'h0A);
      vin[0] = 1'b0;
      tick();
      check("rs_lane1", int'(lane_id), 1);
      check("rs_data1", int'(data_out), 8'h1B);
      vin = '0;
      tick();

`ifdef PHY_SCHED_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (TC) tick();
      vin[0] = 1'b1; din[0] = 8'h5A;
      repeat (300) tick();
      vin[0] = 1'b0;
      check("st_cnt0", int'(cnt[0]), 8'hFF);
      check("st_cnt1", int'(cnt[1]), 0);
      check("st_cnt3", int'(cnt[3]), 0);
      retrain = 1'b1;
      tick();
      retrain = 1'b0;
      repeat (2) tick();
      check("st_cnt0_rt", int'(cnt[0]), 8'hFF);
`endif

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
